// File: rtl/layer_arbiter.sv
// Layer arbiter: per-pixel priority mux over NUM_LAYERS drawing layers with a shadow
// priority table committed at frame start. Optional LAYER_BLINK_EN adds frame-counted blink blanking.
module layer_arbiter #(
    parameter int NUM_LAYERS   = 8,
    parameter int BLINK_PERIOD = 16
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic [NUM_LAYERS-1:0]      layerDR,
    input  logic [NUM_LAYERS-1:0][7:0] layerRGB,
    input  logic [7:0]                 backGroundRGB,
    input  logic                       cfgValid,
    output logic                       cfgReady,
    input  logic [2:0]                 cfgSlot,
    input  logic [2:0]                 cfgLayer,
    input  logic                       cfgBlink,
    output logic [7:0]                 RGBOut,
    output logic [3:0]                 winLayer,
    output logic                       overlap
);
    typedef enum logic [1:0] {IDLE, DIRTY, COMMIT} cfg_state_e;
    typedef logic [NUM_LAYERS-1:0][2:0] prio_table_t;

    cfg_state_e            state_q, state_d;
    prio_table_t           active_tbl_q, active_tbl_d;
    prio_table_t           shadow_tbl_q, shadow_tbl_d;
    logic [7:0]            rgb_q, rgb_d;
    logic [3:0]            win_q, win_d;
    logic                  overlap_q, overlap_d;
    logic [NUM_LAYERS-1:0] eligible;
    logic                  cfg_accept;
    logic                  cfg_legal;
    logic                  cfg_write;

    assign cfgReady   = (state_q != COMMIT);
    assign cfg_accept = cfgValid && cfgReady;
    // Out-of-range writes still complete the handshake but must leave every table untouched.
    assign cfg_legal  = (int'(cfgSlot) < NUM_LAYERS) && (int'(cfgLayer) < NUM_LAYERS);
    assign cfg_write  = cfg_accept && cfg_legal;

`ifdef LAYER_BLINK_EN
    localparam int CNT_W = $clog2(BLINK_PERIOD);

    logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic [NUM_LAYERS-1:0] active_blink_q, active_blink_d;
    logic [NUM_LAYERS-1:0] shadow_blink_q, shadow_blink_d;

    always_comb begin
        frame_cnt_d    = frame_cnt_q;
        shadow_blink_d = shadow_blink_q;
        active_blink_d = active_blink_q;
        if (startOfFrame)
            frame_cnt_d = (int'(frame_cnt_q) == BLINK_PERIOD - 1) ? '0 : frame_cnt_q + CNT_W'(1);
        if (cfg_write)
            for (int l = 0; l < NUM_LAYERS; l++)
                if (cfgLayer == 3'(l)) shadow_blink_d[l] = cfgBlink;
        if (state_q == COMMIT)
            active_blink_d = shadow_blink_q;
    end

    // Second half of every blink period hides the blinking layers.
    assign eligible = (int'(frame_cnt_q) >= BLINK_PERIOD / 2) ? (layerDR & ~active_blink_q) : layerDR;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt_q    <= '0;
            active_blink_q <= '0;
            shadow_blink_q <= '0;
        end else begin
            frame_cnt_q    <= frame_cnt_d;
            active_blink_q <= active_blink_d;
            shadow_blink_q <= shadow_blink_d;
        end
    end
`else
    logic unused_blink;

    assign unused_blink = cfgBlink | (BLINK_PERIOD == 0);
    assign eligible     = layerDR;
`endif

    // NOTE: every variable gets a default before any branch so always_comb never infers a latch.
    always_comb begin
        state_d      = state_q;
        shadow_tbl_d = shadow_tbl_q;
        active_tbl_d = active_tbl_q;
        if (cfg_write)
            for (int k = 0; k < NUM_LAYERS; k++)
                if (cfgSlot == 3'(k)) shadow_tbl_d[k] = cfgLayer;
        unique case (state_q)
            IDLE:    if (cfg_write) state_d = DIRTY;
            DIRTY:   if (startOfFrame) state_d = COMMIT;
            COMMIT: begin
                active_tbl_d = shadow_tbl_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Walk slots from lowest priority upward so the lowest matching slot is written last.
    always_comb begin
        rgb_d = backGroundRGB;
        win_d = 4'(NUM_LAYERS);
        for (int k = NUM_LAYERS - 1; k >= 0; k--)
            for (int l = 0; l < NUM_LAYERS; l++)
                if (eligible[l] && active_tbl_q[k] == 3'(l)) begin
                    rgb_d = layerRGB[l];
                    win_d = 4'(l);
                end
        overlap_d = ($countones(eligible) >= 2);
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of order.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            rgb_q     <= '0;
            win_q     <= 4'(NUM_LAYERS);
            overlap_q <= 1'b0;
            // NOTE: the tables are small flop arrays whose identity reset value is functional, so they are reset.
            for (int k = 0; k < NUM_LAYERS; k++) begin
                active_tbl_q[k] <= 3'(k);
                shadow_tbl_q[k] <= 3'(k);
            end
        end else begin
            state_q      <= state_d;
            active_tbl_q <= active_tbl_d;
            shadow_tbl_q <= shadow_tbl_d;
            rgb_q        <= rgb_d;
            win_q        <= win_d;
            overlap_q    <= overlap_d;
        end
    end

    assign RGBOut   = rgb_q;
    assign winLayer = win_q;
    assign overlap  = overlap_q;
endmodule

// File: tb/tb_layer_arbiter.sv
// Directed bench for layer_arbiter: an 8-layer and a 6-layer instance share stimulus;
// blink expectations follow whether LAYER_BLINK_EN is defined for the build.
module tb_layer_arbiter;
`ifdef LAYER_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            resetN;
    logic            start_of_frame;
    logic [7:0]      layer_dr;
    logic [7:0][7:0] layer_rgb;
    logic [7:0]      bg_rgb;
    logic            cfg_valid;
    logic [2:0]      cfg_slot;
    logic [2:0]      cfg_layer;
    logic            cfg_blink;
    logic            ready8, ready6;
    logic [7:0]      rgb8, rgb6;
    logic [3:0]      win8, win6;
    logic            ovl8, ovl6;
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    layer_arbiter #(.NUM_LAYERS(8), .BLINK_PERIOD(4)) u_dut8 (
        .clk(clk), .resetN(resetN), .startOfFrame(start_of_frame),
        .layerDR(layer_dr), .layerRGB(layer_rgb), .backGroundRGB(bg_rgb),
        .cfgValid(cfg_valid), .cfgReady(ready8), .cfgSlot(cfg_slot), .cfgLayer(cfg_layer),
        .cfgBlink(cfg_blink), .RGBOut(rgb8), .winLayer(win8), .overlap(ovl8)
    );

    layer_arbiter #(.NUM_LAYERS(6), .BLINK_PERIOD(4)) u_dut6 (
        .clk(clk), .resetN(resetN), .startOfFrame(start_of_frame),
        .layerDR(layer_dr[5:0]), .layerRGB(layer_rgb[5:0]), .backGroundRGB(bg_rgb),
        .cfgValid(cfg_valid), .cfgReady(ready6), .cfgSlot(cfg_slot), .cfgLayer(cfg_layer),
        .cfgBlink(cfg_blink), .RGBOut(rgb6), .winLayer(win6), .overlap(ovl6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sof();
        start_of_frame = 1'b1;
        step();
        start_of_frame = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] slot, input logic [2:0] layer, input logic blink);
        check("cfg_ready_before_write", ready8, 1);
        cfg_slot  = slot;
        cfg_layer = layer;
        cfg_blink = blink;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        step();
        step();
        resetN = 1'b1;
    endtask

    initial begin
        start_of_frame = 1'b0;
        layer_dr       = '0;
        bg_rgb         = 8'h0F;
        cfg_valid      = 1'b0;
        cfg_slot       = '0;
        cfg_layer      = '0;
        cfg_blink      = 1'b0;
        layer_rgb      = {8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h1C, 8'hE0, 8'h03};

        // Reset values held while resetN is low
        resetN = 1'b0;
        step();
        step();
        check("rst_rgb", rgb8, 8'h00);
        check("rst_win", win8, 8);
        check("rst_overlap", ovl8, 0);
        check("rst_ready", ready8, 1);
        check("rst_win6", win6, 6);
        resetN = 1'b1;

        // Background with no requests, then basic priority and overlap
        step();
        check("bg_rgb", rgb8, 8'h0F);
        check("bg_win", win8, 8);
        layer_dr = 8'b0000_0110;
        step();
        check("l1_rgb", rgb8, 8'hE0);
        check("l1_win", win8, 1);
        check("l1_overlap", ovl8, 1);
        check("l1_rgb6", rgb6, 8'hE0);
        layer_dr = 8'b1000_0000;
        step();
        check("l7_rgb", rgb8, 8'h77);
        check("l7_win", win8, 7);
        check("l7_overlap", ovl8, 0);
        check("l7_win6_bg", win6, 6);
        check("l7_rgb6_bg", rgb6, 8'h0F);

        // slot0 <- layer2 takes effect only after the frame-start commit
        layer_dr = 8'b0000_0110;
        cfg_write(3'd0, 3'd2, 1'b0);
        check("dirty_ready", ready8, 1);
        step();
        check("dirty_rgb_hold", rgb8, 8'hE0);
        pulse_sof();
        check("commit_ready", ready8, 0);
        check("commit_ready6", ready6, 0);
        check("commit_rgb_hold", rgb8, 8'hE0);
        step();
        check("post_commit_ready", ready8, 1);
        check("post_commit_rgb_hold", rgb8, 8'hE0);
        step();
        check("new_tbl_rgb", rgb8, 8'h1C);
        check("new_tbl_win", win8, 2);
        check("new_tbl_rgb6", rgb6, 8'h1C);

        // layer0 no longer appears in any slot
        layer_dr = 8'b0000_0001;
        step();
        check("absent_rgb", rgb8, 8'h0F);
        check("absent_win", win8, 8);

        // Write coincident with startOfFrame while DIRTY joins that commit
        cfg_write(3'd1, 3'd4, 1'b0);
        cfg_slot       = 3'd3;
        cfg_layer      = 3'd5;
        cfg_valid      = 1'b1;
        start_of_frame = 1'b1;
        check("coincident_ready", ready8, 1);
        step();
        cfg_valid      = 1'b0;
        start_of_frame = 1'b0;
        check("coincident_commit_ready", ready8, 0);
        step();
        layer_dr = 8'b0010_1000;
        step();
        check("slot3_rgb", rgb8, 8'h55);
        check("slot3_win", win8, 5);
        check("slot3_overlap", ovl8, 1);
        check("slot3_rgb6", rgb6, 8'h55);
        layer_dr = 8'b0011_0000;
        step();
        check("slot1_rgb", rgb8, 8'h44);
        check("slot1_win", win8, 4);

        // Out-of-range writes for the 6-layer instance are swallowed
        cfg_write(3'd7, 3'd1, 1'b0);
        cfg_write(3'd0, 3'd7, 1'b0);
        pulse_sof();
        check("range_commit_ready8", ready8, 0);
        check("range_no_commit_ready6", ready6, 1);
        step();
        layer_dr = 8'b1000_0100;
        step();
        check("range_rgb8", rgb8, 8'h77);
        check("range_win8", win8, 7);
        check("range_rgb6", rgb6, 8'h1C);
        check("range_win6", win6, 2);

        // startOfFrame while IDLE does not commit
        pulse_sof();
        check("idle_sof_ready", ready8, 1);
        check("idle_sof_ready6", ready6, 1);

        // Reset while DIRTY discards the pending write
        cfg_write(3'd0, 3'd3, 1'b0);
        resetN = 1'b0;
        step();
        check("mid_rst_rgb", rgb8, 8'h00);
        check("mid_rst_win", win8, 8);
        check("mid_rst_ready", ready8, 1);
        resetN   = 1'b1;
        layer_dr = 8'b0000_1010;
        step();
        check("post_rst_rgb", rgb8, 8'hE0);
        check("post_rst_win", win8, 1);
        pulse_sof();
        check("post_rst_sof_ready", ready8, 1);
        step();
        step();
        check("post_rst_tbl_rgb", rgb8, 8'hE0);
        check("post_rst_tbl_win", win8, 1);

        // Blink on layer0 with a 4-frame period
        do_reset();
        layer_dr = 8'b0000_0001;
        cfg_write(3'd0, 3'd0, 1'b1);
        check("frame0_win", win8, 0);
        pulse_sof();
        step();
        step();
        check("frame1_rgb", rgb8, 8'h03);
        check("frame1_win", win8, 0);
        pulse_sof();
        step();
        check("frame2_rgb", rgb8, BLINK_ON ? 8'h0F : 8'h03);
        check("frame2_win", win8, BLINK_ON ? 8 : 0);
        pulse_sof();
        layer_dr = 8'b0000_0011;
        step();
        check("frame3_rgb", rgb8, BLINK_ON ? 8'hE0 : 8'h03);
        check("frame3_win", win8, BLINK_ON ? 1 : 0);
        check("frame3_overlap", ovl8, BLINK_ON ? 0 : 1);
        layer_dr = 8'b0000_0001;
        pulse_sof();
        step();
        check("frame4_rgb", rgb8, 8'h03);
        check("frame4_win", win8, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
